// File: rtl/id_stage_pipe.sv
// id_stage_pipe
// Pipelined decode stage: register bank with write-through bypass, RV32
// instruction decode, and a registered ID/EX boundary. Both sides use
// valid/ready handshakes. Load-use hazards insert one bubble. Operands held
// in ID/EX are refreshed by writebacks, and a flush discards ID/EX along
// with the incoming instruction.
//
// Ports
//   clk, rst_n                     clock, asynchronous active-low reset
//   instr_valid_i/instr_i/pc_i     fetch side instruction, ready via instr_ready_o
//   flush_i                        drop ID/EX and the incoming instruction
//   reg_wen_i/reg_waddr_i/reg_wdata_i  writeback port into the bank
//   ex_valid_o/ex_ready_i          execute side handshake
//   ex_*                           registered decode payload
module id_stage_pipe #(
    parameter int WORD_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 5,
    parameter int ALU_OP_WIDTH = 4,
    parameter int HAZARD_EN    = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    instr_valid_i,
    input  logic [WORD_WIDTH-1:0]   instr_i,
    input  logic [WORD_WIDTH-1:0]   pc_i,
    output logic                    instr_ready_o,
    input  logic                    flush_i,
    input  logic                    reg_wen_i,
    input  logic [ADDR_WIDTH-1:0]   reg_waddr_i,
    input  logic [WORD_WIDTH-1:0]   reg_wdata_i,
    output logic                    ex_valid_o,
    input  logic                    ex_ready_i,
    output logic [WORD_WIDTH-1:0]   ex_pc_o,
    output logic [WORD_WIDTH-1:0]   ex_rdata1_o,
    output logic [WORD_WIDTH-1:0]   ex_rdata2_o,
    output logic [ADDR_WIDTH-1:0]   ex_rs1_o,
    output logic [ADDR_WIDTH-1:0]   ex_rs2_o,
    output logic [ADDR_WIDTH-1:0]   ex_rd_o,
    output logic [ALU_OP_WIDTH-1:0] ex_alu_op_o,
    output logic [2:0]              ex_load_type_o,
    output logic [1:0]              ex_store_type_o,
    output logic [9:0]              ex_ctrl_o,
    output logic                    ex_is_load_o
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    logic [WORD_WIDTH-1:0]   bank_r [DEPTH];

    logic                    ex_valid_r;
    logic [WORD_WIDTH-1:0]   ex_pc_r;
    logic [WORD_WIDTH-1:0]   ex_rdata1_r;
    logic [WORD_WIDTH-1:0]   ex_rdata2_r;
    logic [ADDR_WIDTH-1:0]   ex_rs1_r;
    logic [ADDR_WIDTH-1:0]   ex_rs2_r;
    logic [ADDR_WIDTH-1:0]   ex_rd_r;
    logic [ALU_OP_WIDTH-1:0] ex_alu_op_r;
    logic [2:0]              ex_load_type_r;
    logic [1:0]              ex_store_type_r;
    logic [9:0]              ex_ctrl_r;
    logic                    ex_is_load_r;

    logic [ADDR_WIDTH-1:0]   rs1_s, rs2_s, rd_s;
    logic [6:0]              opcode_s, funct7_s;
    logic [2:0]              funct3_s;
    logic [WORD_WIDTH-1:0]   rdata1_s, rdata2_s;
    logic [3:0]              alu4_s;
    logic [2:0]              load_type_s;
    logic [1:0]              store_type_s;
    logic [9:0]              ctrl_s;
    logic                    slot_free_s, hz_s, accept_s;
    logic                    wr_live_s;

    assign opcode_s  = instr_i[6:0];
    assign funct3_s  = instr_i[14:12];
    assign funct7_s  = instr_i[31:25];
    assign rs1_s     = instr_i[15 +: ADDR_WIDTH];
    assign rs2_s     = instr_i[20 +: ADDR_WIDTH];
    assign rd_s      = instr_i[7 +: ADDR_WIDTH];
    assign wr_live_s = reg_wen_i && (reg_waddr_i != '0);

    // Operand read with x0 forced to zero and same-cycle writeback bypass.
    always_comb begin
        rdata1_s = '0;
        rdata2_s = '0;
        if (rs1_s == '0) begin
            rdata1_s = '0;
        end else if (wr_live_s && (reg_waddr_i == rs1_s)) begin
            rdata1_s = reg_wdata_i;
        end else begin
            rdata1_s = bank_r[rs1_s];
        end
        if (rs2_s == '0) begin
            rdata2_s = '0;
        end else if (wr_live_s && (reg_waddr_i == rs2_s)) begin
            rdata2_s = reg_wdata_i;
        end else begin
            rdata2_s = bank_r[rs2_s];
        end
    end

    // Instruction decode. ctrl = {write_en, stype, imm_alu, jarl, jal, branch,
    // auipc, lui, zeroflag, mdu_op}. alu4 = {funct7[5] where it selects
    // sub/sra, funct3}; branches use subtract (4'b1000). zeroflag marks the
    // equality branches (funct3[2]==0: beq/bne), which test the zero result.
    always_comb begin
        alu4_s       = 4'b0000;
        load_type_s  = 3'b000;
        store_type_s = 2'b00;
        ctrl_s       = 10'b0000000000;
        case (opcode_s)
            OPC_OP: begin
                ctrl_s[9] = 1'b1;
                if (funct7_s == 7'b0000001) begin
                    ctrl_s[0] = 1'b1;
                    alu4_s    = {1'b0, funct3_s};
                end else begin
                    alu4_s    = {funct7_s[5], funct3_s};
                end
            end
            OPC_OPIMM: begin
                ctrl_s[9] = 1'b1;
                ctrl_s[7] = 1'b1;
                alu4_s    = {(funct3_s == 3'b101) ? funct7_s[5] : 1'b0, funct3_s};
            end
            OPC_LOAD: begin
                ctrl_s[9]   = 1'b1;
                ctrl_s[7]   = 1'b1;
                load_type_s = funct3_s;
            end
            OPC_STORE: begin
                ctrl_s[8]    = 1'b1;
                ctrl_s[7]    = 1'b1;
                store_type_s = funct3_s[1:0];
            end
            OPC_BRANCH: begin
                ctrl_s[4] = 1'b1;
                ctrl_s[1] = ~funct3_s[2];
                alu4_s    = 4'b1000;
            end
            OPC_JALR: begin
                ctrl_s[9] = 1'b1;
                ctrl_s[7] = 1'b1;
                ctrl_s[6] = 1'b1;
            end
            OPC_JAL: begin
                ctrl_s[9] = 1'b1;
                ctrl_s[5] = 1'b1;
            end
            OPC_AUIPC: begin
                ctrl_s[9] = 1'b1;
                ctrl_s[3] = 1'b1;
            end
            OPC_LUI: begin
                ctrl_s[9] = 1'b1;
                ctrl_s[2] = 1'b1;
            end
            default: begin
                ctrl_s = 10'b0000000000;
            end
        endcase
    end

    // Handshake: both rs fields are compared whatever the format, so
    // the hazard check is conservative for formats without rs2.
    assign slot_free_s   = !ex_valid_r || ex_ready_i;
    assign hz_s          = (HAZARD_EN != 0) && ex_valid_r && ex_is_load_r &&
                           (ex_rd_r != '0) &&
                           ((ex_rd_r == rs1_s) || (ex_rd_r == rs2_s));
    assign instr_ready_o = flush_i || (slot_free_s && !hz_s);
    assign accept_s      = instr_valid_i && instr_ready_o && !flush_i;

    // Register bank write; x0 is never written so it stays zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                bank_r[i] <= '0;
            end
        end else if (wr_live_s) begin
            bank_r[reg_waddr_i] <= reg_wdata_i;
        end else begin
            bank_r[0] <= '0;
        end
    end

    // ID/EX register: flush > accept > bubble > hold (with operand refresh).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_r      <= 1'b0;
            ex_pc_r         <= '0;
            ex_rdata1_r     <= '0;
            ex_rdata2_r     <= '0;
            ex_rs1_r        <= '0;
            ex_rs2_r        <= '0;
            ex_rd_r         <= '0;
            ex_alu_op_r     <= '0;
            ex_load_type_r  <= 3'b000;
            ex_store_type_r <= 2'b00;
            ex_ctrl_r       <= 10'b0000000000;
            ex_is_load_r    <= 1'b0;
        end else if (flush_i) begin
            ex_valid_r      <= 1'b0;
        end else if (accept_s) begin
            ex_valid_r      <= 1'b1;
            ex_pc_r         <= pc_i;
            ex_rdata1_r     <= rdata1_s;
            ex_rdata2_r     <= rdata2_s;
            ex_rs1_r        <= rs1_s;
            ex_rs2_r        <= rs2_s;
            ex_rd_r         <= rd_s;
            ex_alu_op_r     <= ALU_OP_WIDTH'(alu4_s);
            ex_load_type_r  <= load_type_s;
            ex_store_type_r <= store_type_s;
            ex_ctrl_r       <= ctrl_s;
            ex_is_load_r    <= (opcode_s == OPC_LOAD);
        end else if (slot_free_s) begin
            ex_valid_r      <= 1'b0;
        end else begin
            // Held entry: pick up writebacks to its source registers.
            if (wr_live_s && (reg_waddr_i == ex_rs1_r)) begin
                ex_rdata1_r <= reg_wdata_i;
            end else begin
                ex_rdata1_r <= ex_rdata1_r;
            end
            if (wr_live_s && (reg_waddr_i == ex_rs2_r)) begin
                ex_rdata2_r <= reg_wdata_i;
            end else begin
                ex_rdata2_r <= ex_rdata2_r;
            end
        end
    end

    assign ex_valid_o      = ex_valid_r;
    assign ex_pc_o         = ex_pc_r;
    assign ex_rdata1_o     = ex_rdata1_r;
    assign ex_rdata2_o     = ex_rdata2_r;
    assign ex_rs1_o        = ex_rs1_r;
    assign ex_rs2_o        = ex_rs2_r;
    assign ex_rd_o         = ex_rd_r;
    assign ex_alu_op_o     = ex_alu_op_r;
    assign ex_load_type_o  = ex_load_type_r;
    assign ex_store_type_o = ex_store_type_r;
    assign ex_ctrl_o       = ex_ctrl_r;
    assign ex_is_load_o    = ex_is_load_r;

endmodule

// File: tb/tb_id_stage_pipe.sv
// tb_id_stage_pipe
// Self-checking bench for id_stage_pipe: a table of streamed instructions
// plus hand-written hazard/hold/flush/reset sequences. Expected ID/EX records
// are queued when driven and compared when the stage hands them to execute.
// A second instance with HAZARD_EN=0 shares the inputs for the no-bubble case.
module tb_id_stage_pipe;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [4:0]  rd;
        logic [9:0]  ctrl;
        logic [3:0]  alu;
        logic        is_load;
    } exp_t;

    typedef struct {
        logic [31:0] instr;
        logic        wen;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        exp_t        e;
    } vec_t;

    localparam logic [31:0] I_ADDI_X1 = 32'h00500093; // addi x1,x0,5
    localparam logic [31:0] I_ADD_X2  = 32'h00108133; // add  x2,x1,x1
    localparam logic [31:0] I_SUB_X8  = 32'h40208433; // sub  x8,x1,x2
    localparam logic [31:0] I_ADD_X7  = 32'h000003B3; // add  x7,x0,x0
    localparam logic [31:0] I_ADDI_X9 = 32'h00110493; // addi x9,x2,1
    localparam logic [31:0] I_LW_X3   = 32'h00002183; // lw   x3,0(x0)
    localparam logic [31:0] I_ADD_X4  = 32'h00018233; // add  x4,x3,x0
    localparam logic [31:0] I_ADD_X6  = 32'h00028333; // add  x6,x5,x0

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        flush;
    logic        reg_wen;
    logic [4:0]  reg_waddr;
    logic [31:0] reg_wdata;
    logic        ex_ready;

    logic        instr_ready, ex_valid, ex_is_load;
    logic [31:0] ex_pc, ex_rdata1, ex_rdata2;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [3:0]  ex_alu_op;
    logic [2:0]  ex_load_type;
    logic [1:0]  ex_store_type;
    logic [9:0]  ex_ctrl;

    logic        h0_instr_ready, h0_ex_valid, h0_ex_is_load;
    logic [31:0] h0_ex_pc, h0_ex_rdata1, h0_ex_rdata2;
    logic [4:0]  h0_ex_rs1, h0_ex_rs2, h0_ex_rd;
    logic [3:0]  h0_ex_alu_op;
    logic [2:0]  h0_ex_load_type;
    logic [1:0]  h0_ex_store_type;
    logic [9:0]  h0_ex_ctrl;

    int n_cmp = 0;
    int n_err = 0;
    exp_t sb_q[$];
    vec_t vecs[6];

    always #5 clk = ~clk;

    id_stage_pipe #(.HAZARD_EN(1)) dut (
        .clk(clk), .rst_n(rst_n), .instr_valid_i(instr_valid), .instr_i(instr),
        .pc_i(pc), .instr_ready_o(instr_ready), .flush_i(flush),
        .reg_wen_i(reg_wen), .reg_waddr_i(reg_waddr), .reg_wdata_i(reg_wdata),
        .ex_valid_o(ex_valid), .ex_ready_i(ex_ready), .ex_pc_o(ex_pc),
        .ex_rdata1_o(ex_rdata1), .ex_rdata2_o(ex_rdata2), .ex_rs1_o(ex_rs1),
        .ex_rs2_o(ex_rs2), .ex_rd_o(ex_rd), .ex_alu_op_o(ex_alu_op),
        .ex_load_type_o(ex_load_type), .ex_store_type_o(ex_store_type),
        .ex_ctrl_o(ex_ctrl), .ex_is_load_o(ex_is_load)
    );

    id_stage_pipe #(.HAZARD_EN(0)) dut_nohz (
        .clk(clk), .rst_n(rst_n), .instr_valid_i(instr_valid), .instr_i(instr),
        .pc_i(pc), .instr_ready_o(h0_instr_ready), .flush_i(flush),
        .reg_wen_i(reg_wen), .reg_waddr_i(reg_waddr), .reg_wdata_i(reg_wdata),
        .ex_valid_o(h0_ex_valid), .ex_ready_i(ex_ready), .ex_pc_o(h0_ex_pc),
        .ex_rdata1_o(h0_ex_rdata1), .ex_rdata2_o(h0_ex_rdata2), .ex_rs1_o(h0_ex_rs1),
        .ex_rs2_o(h0_ex_rs2), .ex_rd_o(h0_ex_rd), .ex_alu_op_o(h0_ex_alu_op),
        .ex_load_type_o(h0_ex_load_type), .ex_store_type_o(h0_ex_store_type),
        .ex_ctrl_o(h0_ex_ctrl), .ex_is_load_o(h0_ex_is_load)
    );

    function automatic exp_t mk_exp(logic [31:0] p, logic [31:0] r1, logic [31:0] r2,
                                    logic [4:0] rd, logic [9:0] c, logic [3:0] a, logic ld);
        exp_t e;
        e.pc = p; e.rd1 = r1; e.rd2 = r2; e.rd = rd; e.ctrl = c; e.alu = a; e.is_load = ld;
        return e;
    endfunction

    function automatic vec_t mk_vec(logic [31:0] ins, logic we, logic [4:0] wa,
                                    logic [31:0] wd, exp_t e);
        vec_t v;
        v.instr = ins; v.wen = we; v.waddr = wa; v.wdata = wd; v.e = e;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] p);
        instr_valid = v;
        instr = ins;
        pc = p;
    endtask

    // Scoreboard: every instruction handed to execute must match the queue head.
    always @(negedge clk) begin
        if (rst_n && ex_valid && ex_ready) begin
            exp_t e;
            n_cmp++;
            if (sb_q.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected: got pc 0x%08h expected no output", ex_pc);
            end else begin
                e = sb_q.pop_front();
                if (ex_pc !== e.pc || ex_rdata1 !== e.rd1 || ex_rdata2 !== e.rd2 ||
                    ex_rd !== e.rd || ex_ctrl !== e.ctrl || ex_alu_op !== e.alu ||
                    ex_is_load !== e.is_load) begin
                    n_err++;
                    $display("FAIL sb_record: got pc=%h r1=%h r2=%h rd=%0d ctrl=%h alu=%h ld=%b expected pc=%h r1=%h r2=%h rd=%0d ctrl=%h alu=%h ld=%b",
                             ex_pc, ex_rdata1, ex_rdata2, ex_rd, ex_ctrl, ex_alu_op, ex_is_load,
                             e.pc, e.rd1, e.rd2, e.rd, e.ctrl, e.alu, e.is_load);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        vecs[0] = mk_vec(I_ADDI_X1, 1'b0, 5'd0, 32'h0,
                         mk_exp(32'h100, 32'd0, 32'd0, 5'd1, 10'h280, 4'h0, 1'b0));
        vecs[1] = mk_vec(I_ADD_X2, 1'b1, 5'd1, 32'd5,
                         mk_exp(32'h104, 32'd5, 32'd5, 5'd2, 10'h200, 4'h0, 1'b0));
        vecs[2] = mk_vec(I_SUB_X8, 1'b1, 5'd2, 32'd10,
                         mk_exp(32'h108, 32'd5, 32'd10, 5'd8, 10'h200, 4'h8, 1'b0));
        vecs[3] = mk_vec(I_ADD_X7, 1'b1, 5'd0, 32'hFFFFFFFF,
                         mk_exp(32'h10C, 32'd0, 32'd0, 5'd7, 10'h200, 4'h0, 1'b0));
        vecs[4] = mk_vec(I_ADD_X7, 1'b0, 5'd0, 32'h0,
                         mk_exp(32'h110, 32'd0, 32'd0, 5'd7, 10'h200, 4'h0, 1'b0));
        vecs[5] = mk_vec(I_ADDI_X9, 1'b0, 5'd0, 32'h0,
                         mk_exp(32'h114, 32'd10, 32'd5, 5'd9, 10'h280, 4'h0, 1'b0));

        rst_n = 1'b0; flush = 1'b0; ex_ready = 1'b1;
        reg_wen = 1'b0; reg_waddr = 5'd0; reg_wdata = 32'd0;
        drive(1'b0, 32'd0, 32'd0);
        step(); step();
        chk("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("rst_ex_pc", ex_pc, 32'd0);
        chk("rst_ex_rdata1", ex_rdata1, 32'd0);
        chk("rst_ex_ctrl", {22'd0, ex_ctrl}, 32'd0);
        chk("rst_instr_ready", {31'd0, instr_ready}, 32'd1);
        rst_n = 1'b1;
        step();

        // Table stream at full throughput.
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, vecs[i].instr, vecs[i].e.pc);
            reg_wen = vecs[i].wen; reg_waddr = vecs[i].waddr; reg_wdata = vecs[i].wdata;
            sb_q.push_back(vecs[i].e);
            step();
        end
        drive(1'b0, 32'd0, 32'd0);
        reg_wen = 1'b0;
        step(); step();

        // Load-use: one bubble with hazard detection, none without.
        drive(1'b1, I_LW_X3, 32'h200);
        sb_q.push_back(mk_exp(32'h200, 32'd0, 32'd0, 5'd3, 10'h280, 4'h0, 1'b1));
        step();
        drive(1'b1, I_ADD_X4, 32'h204);
        sb_q.push_back(mk_exp(32'h204, 32'd0, 32'd0, 5'd4, 10'h200, 4'h0, 1'b0));
        #1;
        chk("lu_ready_stall", {31'd0, instr_ready}, 32'd0);
        chk("lu_nohz_ready", {31'd0, h0_instr_ready}, 32'd1);
        step();
        chk("lu_bubble", {31'd0, ex_valid}, 32'd0);
        chk("lu_nohz_valid", {31'd0, h0_ex_valid}, 32'd1);
        chk("lu_nohz_pc", h0_ex_pc, 32'h204);
        step();
        chk("lu_dep_valid", {31'd0, ex_valid}, 32'd1);
        chk("lu_dep_pc", ex_pc, 32'h204);
        drive(1'b0, 32'd0, 32'd0);
        step(); step();

        // Hold for three cycles with a refresh of x5 in the middle.
        drive(1'b1, I_ADD_X6, 32'h300);
        sb_q.push_back(mk_exp(32'h300, 32'hDEADBEEF, 32'd0, 5'd6, 10'h200, 4'h0, 1'b0));
        step();
        ex_ready = 1'b0;
        drive(1'b1, I_ADD_X7, 32'h304);
        for (int k = 0; k < 3; k++) begin
            reg_wen = (k == 1); reg_waddr = 5'd5; reg_wdata = 32'hDEADBEEF;
            #1;
            chk("hold_ready", {31'd0, instr_ready}, 32'd0);
            step();
        end
        reg_wen = 1'b0;
        chk("hold_refresh", ex_rdata1, 32'hDEADBEEF);
        ex_ready = 1'b1;
        sb_q.push_back(mk_exp(32'h304, 32'd0, 32'd0, 5'd7, 10'h200, 4'h0, 1'b0));
        step();
        drive(1'b0, 32'd0, 32'd0);
        step(); step();

        // Flush with a valid held entry and a valid incoming instruction.
        drive(1'b1, I_ADD_X7, 32'h400);
        step();
        ex_ready = 1'b0;
        flush = 1'b1;
        drive(1'b1, I_SUB_X8, 32'h404);
        #1;
        chk("flush_ready", {31'd0, instr_ready}, 32'd1);
        step();
        chk("flush_valid", {31'd0, ex_valid}, 32'd0);

        // Flush together with a load-use hazard.
        flush = 1'b0; ex_ready = 1'b1;
        drive(1'b1, I_LW_X3, 32'h500);
        step();
        ex_ready = 1'b0;
        flush = 1'b1;
        drive(1'b1, I_ADD_X4, 32'h504);
        #1;
        chk("flush_hz_ready", {31'd0, instr_ready}, 32'd1);
        step();
        chk("flush_hz_valid", {31'd0, ex_valid}, 32'd0);
        flush = 1'b0; ex_ready = 1'b1;
        drive(1'b0, 32'd0, 32'd0);
        step(); step();

        // Asynchronous reset mid-stream.
        drive(1'b1, I_ADD_X2, 32'h600);
        step();
        ex_ready = 1'b0;
        drive(1'b0, 32'd0, 32'd0);
        chk("pre_rst_valid", {31'd0, ex_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {31'd0, ex_valid}, 32'd0);
        chk("async_rst_pc", ex_pc, 32'd0);
        step();
        rst_n = 1'b1;
        ex_ready = 1'b1;
        drive(1'b1, I_ADD_X2, 32'h604);
        sb_q.push_back(mk_exp(32'h604, 32'd0, 32'd0, 5'd2, 10'h200, 4'h0, 1'b0));
        step();
        drive(1'b1, I_ADDI_X9, 32'h608);
        sb_q.push_back(mk_exp(32'h608, 32'd0, 32'd0, 5'd9, 10'h280, 4'h0, 1'b0));
        step();
        drive(1'b0, 32'd0, 32'd0);
        step(); step(); step();

        chk("sb_drained", sb_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
